// File: rtl/frame_feeder.sv
// frame_feeder: queues sample triples and presents each one to the filter core
// for a fixed head_flag window followed by a mandatory gap.
module frame_feeder #(
  parameter int WIDTH       = 14,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 32,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_ch2,
  input  logic [WIDTH-1:0]         in_ch3,
  input  logic [WIDTH-1:0]         in_ref,
  output logic [WIDTH-1:0]         buffer_2,
  output logic [WIDTH-1:0]         buffer_3,
  output logic [WIDTH-1:0]         reff,
  output logic                     head_flag,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2((HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        lvl_q, lvl_d;
  logic [3*WIDTH-1:0] mem [DEPTH];
  logic [3*WIDTH-1:0] buf_q, buf_d;
  logic               head_q, head_d, ovf_q, push, pop, last;
  assign in_ready   = !rst && lvl_q != (AW+1)'(DEPTH);
  assign push       = in_valid && in_ready;
  assign pop        = state_q == IDLE && lvl_q != '0;
  assign lvl_d      = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
  assign last       = cnt_q == (state_q == HOLD ? CW'(HOLD_CYCLES - 1) : CW'(GAP_CYCLES - 1));
  assign {buffer_2, buffer_3, reff} = buf_q;
  assign head_flag  = head_q;
  assign fifo_level = lvl_q;
  assign overflow   = ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      buf_q   <= '0;
      head_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      lvl_q   <= lvl_d;
      buf_q   <= buf_d;
      head_q  <= head_d;
      ovf_q   <= ovf_q || (in_valid && !in_ready);
    end
  end
  // storage carries no reset; emptiness is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {in_ch2, in_ch3, in_ref};
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && pop) state_d = HOLD;
    else if (state_q == HOLD && last) state_d = GAP;
    else if (state_q == GAP && last) state_d = IDLE;
  end
  always_comb begin
    cnt_d  = (state_q == IDLE || last) ? '0 : cnt_q + CW'(1);
    head_d = state_d == HOLD;
    buf_d  = pop ? mem[rd_q] : buf_q;
  end
endmodule

// File: tb/tb_frame_feeder.sv
// tb_frame_feeder: random and directed traffic checked cycle by cycle against a
// queue-plus-frame-age reference model.
module tb_frame_feeder;
  localparam int W = 14;
  localparam int D = 16;
  localparam int H = 32;
  localparam int G = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, head_flag, overflow;
  logic [W-1:0] in_ch2 = '0, in_ch3 = '0, in_ref = '0;
  logic [W-1:0] buffer_2, buffer_3, reff;
  logic [$clog2(D):0] fifo_level;
  int total = 0;
  int bad = 0;
  logic [3*W-1:0] q[$];
  logic [3*W-1:0] m_out;
  int age;
  bit m_ovf;

  frame_feeder #(.WIDTH(W), .DEPTH(D), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch2(in_ch2), .in_ch3(in_ch3), .in_ref(in_ref),
    .buffer_2(buffer_2), .buffer_3(buffer_3), .reff(reff),
    .head_flag(head_flag), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // age counts edges since the last pop; a frame occupies ages 0..H+G-1
  task automatic model_reset();
    q.delete();
    age = H + G;
    m_out = '0;
    m_ovf = 1'b0;
  endtask

  task automatic check_all();
    check("head_flag", head_flag, age < H);
    check("fifo_level", fifo_level, q.size());
    check("data", {buffer_2, buffer_3, reff}, m_out);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic step(input bit v, input logic [3*W-1:0] d);
    bit rdy, pp;
    in_valid = v;
    {in_ch2, in_ch3, in_ref} = d;
    rdy = q.size() != D;
    check("in_ready", in_ready, rdy);
    if (v && !rdy) m_ovf = 1'b1;
    pp = age >= H + G && q.size() > 0;
    @(posedge clk);
    if (pp) begin
      m_out = q.pop_front();
      age = 0;
    end else if (age < H + G) age++;
    if (v && rdy) q.push_back(d);
    #1;
    check_all();
  endtask

  function automatic logic [3*W-1:0] rnd();
    return (3*W)'({$urandom(), $urandom()});
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    logic [3*W-1:0] full_pat;
    int guard;
    full_pat = {14'h3FFF, 14'h3FFF, 14'h3FFF};
    model_reset();
    #1;
    check("rst_ready", in_ready, 1'b0);
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);
    // single triple: framed one edge after acceptance, 32 high then 2 low
    step(1'b1, {14'h0123, 14'h0456, 14'h0789});
    idle(40);
    // three back-to-back triples
    for (int i = 0; i < 3; i++) step(1'b1, rnd());
    idle(120);
    // fill to full, then attempt a 0x3FFF write
    for (int i = 0; i < 17; i++) step(1'b1, rnd());
    check("full_level", fifo_level, 16);
    step(1'b1, full_pat);
    check("full_ovf", overflow, 1'b1);
    check("full_ready", in_ready, 1'b0);
    // in_valid held high across IDLE pops while full
    for (int i = 0; i < 80; i++) step(1'b1, rnd());
    idle(18 * (H + G + 1));
    // async reset in the middle of a frame with five triples queued
    for (int i = 0; i < 6; i++) step(1'b1, rnd());
    guard = 0;
    while (age != 10 && guard < 100) begin
      step(1'b0, '0);
      guard++;
    end
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_head", head_flag, 1'b0);
    check("arst_level", fifo_level, 0);
    check("arst_data", {buffer_2, buffer_3, reff}, 0);
    check("arst_ready", in_ready, 1'b0);
    check("arst_ovf", overflow, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_release_ready", in_ready, 1'b1);
    step(1'b1, rnd());
    idle(40);
    // random streaming with varying density, wraps the pointers many times
    for (int p = 0; p < 6; p++) begin
      int den;
      den = (p % 3 == 0) ? 2 : (p % 3 == 1) ? 30 : 60;
      for (int i = 0; i < 500; i++) step($urandom_range(den - 1) == 0, rnd());
    end
    idle(17 * (H + G + 1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_feeder.md
FRAME_FEEDER -- requirements
Module: frame_feeder

Interface
REQ-001 Parameter WIDTH, default 14, shall set the sample width of every data port.
REQ-002 Parameter DEPTH, default 16, shall set the input FIFO depth in sample triples; it shall be a power of two, at least 2.
REQ-003 Parameter HOLD_CYCLES, default 32, shall set the number of cycles head_flag stays high per frame; minimum 18.
REQ-004 Parameter GAP_CYCLES, default 2, shall set the number of cycles head_flag stays low between frames; minimum 1.
REQ-005 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  shall be the asynchronous, active-high reset.
REQ-007 in_valid  input  1  shall mark a valid sample triple on in_ch2/in_ch3/in_ref.
REQ-008 in_ready  output  1  shall indicate the FIFO can accept a triple this cycle.
REQ-009 in_ch2, in_ch3, in_ref  input  WIDTH each  shall carry the sample triple: channel-2, channel-3 and reference.
REQ-010 buffer_2, buffer_3, reff  output  WIDTH each  shall be the registered sample triple presented to the downstream filter core.
REQ-011 head_flag  output  1  shall be the registered frame-window strobe to the filter core.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  shall give the current FIFO occupancy.
REQ-013 overflow  output  1  shall be a sticky flag for in_valid seen while in_ready is low.

Function
REQ-014 A triple shall be accepted on a rising edge where in_valid and in_ready are both 1; in_ready shall equal (fifo_level != DEPTH) and shall not depend on in_valid.
REQ-015 The FIFO shall be first-in first-out; fifo_level shall rise by 1 on accept-only, fall by 1 on pop-only, and stay unchanged on simultaneous accept and pop.
REQ-016 The FSM shall have three states: IDLE, HOLD and GAP.
REQ-017 IDLE: head_flag = 0; if fifo_level > 0, the block shall pop one triple, load it into buffer_2/buffer_3/reff, clear the cycle counter and enter HOLD on the same edge.
REQ-018 HOLD: head_flag = 1; buffer_2/buffer_3/reff shall stay constant; the counter shall increment each cycle; at counter == HOLD_CYCLES-1 the block shall clear the counter and enter GAP.
REQ-019 GAP: head_flag = 0; data outputs shall hold their last value; at counter == GAP_CYCLES-1 the block shall clear the counter and enter IDLE.
REQ-020 Frames shall never run back-to-back; every HOLD shall be followed by a full GAP, even when the FIFO is non-empty.
REQ-021 Latency: a triple accepted into an empty FIFO in IDLE at edge N shall appear on the outputs, with head_flag = 1, after edge N+1.
REQ-022 Minimum frame period shall be HOLD_CYCLES+GAP_CYCLES+1 cycles; 35 at defaults.
REQ-023 An accept and a pop in the same cycle shall both take effect; when the FIFO is full, a pop on that edge shall not re-enable in_ready until the next cycle.
REQ-024 An attempted write while full shall be dropped, shall set overflow and shall not disturb FIFO contents or pointers.
REQ-025 FIFO pointers shall wrap modulo DEPTH.
REQ-026 The counter shall be wide enough for max(HOLD_CYCLES, GAP_CYCLES) and shall not wrap within a state.
REQ-027 No arithmetic shall be applied to samples; they shall pass through bit-exact.

Reset
REQ-028 While rst = 1: state = IDLE, counter = 0, FIFO emptied (fifo_level = 0), buffer_2/buffer_3/reff = 0, head_flag = 0, overflow = 0, in_ready = 0.
REQ-029 Reset asserted mid-HOLD or mid-GAP shall drop head_flag asynchronously and discard all buffered triples.
REQ-030 After rst deasserts, in_ready shall be 1 on the first cycle, and normal operation shall resume from IDLE.

Verification
REQ-031 Single triple (0x0123, 0x0456, 0x0789) accepted into an empty IDLE block at edge N -> outputs equal the triple after N+1; head_flag high for exactly 32 cycles, then low for 2; fifo_level back to 0.
REQ-032 Push 3 triples back-to-back -> three head_flag pulses of 32 high / 3 low (2 GAP + 1 IDLE), data in push order, outputs never change during HOLD.
REQ-033 Fill 16 triples with no pop, then assert in_valid with 0x3FFF -> in_ready = 0, overflow = 1, fifo_level = 16, 0x3FFF never output.
REQ-034 Full FIFO with in_valid held high during an IDLE pop -> level 16 -> 15 -> 16 with no lost or duplicated triple.
REQ-035 Assert rst at HOLD cycle 10 with 5 triples queued -> head_flag = 0 immediately, fifo_level = 0, data outputs = 0; after release, a new triple is framed normally.
REQ-036 Stream 40 triples with pointer wrap -> output order equals input order across the wrap.
